// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: iterative binary-to-BCD converter (shift-add-3, one bit per clock).
//
// A single-cycle start in IDLE latches the binary input. SHIFT then runs for
// p_data_width cycles and finishes with a one-cycle o_w_done pulse. The
// registered result (o_w_bcd, o_w_overflow, o_w_blank) changes only together
// with that pulse and is held until the next conversion completes.
//
// Handshake: i_w_start is honoured only while o_w_busy is low (IDLE). A start
// seen during SHIFT is ignored and i_w_in is not resampled. A start present in
// the o_w_done cycle is accepted, because the block is already IDLE then.
//
// Optional feature macro: SEQ_BIN2BCD_BLANK_EN
//   defined   -> o_w_blank holds a registered leading-zero mask.
//   undefined -> o_w_blank is tied to zero and no blanking logic exists.
//
// If the value does not fit in p_digits digits, the lower digits still hold the
// exact value mod 10^p_digits and o_w_overflow is set.
module seq_bin2bcd #(
    parameter int p_data_width = 8,
    parameter int p_digits     = 3
) (
    input  logic                      i_w_clk,
    input  logic                      i_w_reset,
    input  logic [p_data_width-1:0]   i_w_in,
    input  logic                      i_w_start,
    output logic                      o_w_busy,
    output logic                      o_w_done,
    output logic [4*p_digits-1:0]     o_w_bcd,
    output logic                      o_w_overflow,
    output logic [p_digits-1:0]       o_w_blank
);

    localparam int c_bcd_w = 4 * p_digits;
    localparam int c_cnt_w = $clog2(p_data_width + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(p_data_width);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_q,    state_d;
    logic [p_data_width-1:0] bin_q,      bin_d;
    logic [c_bcd_w-1:0]      scratch_q,  scratch_d;
    logic                    ovf_flag_q, ovf_flag_d;
    logic [c_cnt_w-1:0]      cnt_q,      cnt_d;
    logic                    done_q,     done_d;
    logic [c_bcd_w-1:0]      bcd_q,      bcd_d;
    logic                    ovf_q,      ovf_d;

    // Scratch digits after the add-3 correction.
    logic [c_bcd_w-1:0]      adj;
    // Scratch after this cycle's shift; the top bit of adj falls off the end.
    logic [c_bcd_w-1:0]      shifted;
    logic                    shift_out;

    // Add 3 to every scratch digit that is 5 or more, so that the following
    // doubling carries correctly into the next decimal digit.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < p_digits; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift {scratch, binary} left by one. The bit that leaves the top digit is
    // the decimal carry out of the top digit, which means the value overflowed.
    assign shift_out = adj[c_bcd_w-1];
    assign shifted   = {adj[c_bcd_w-2:0], bin_q[p_data_width-1]};

    // Next-state and datapath control for the IDLE/SHIFT sequencer.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        ovf_flag_d = ovf_flag_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (i_w_start) begin
                    bin_d      = i_w_in;
                    scratch_d  = '0;
                    ovf_flag_d = 1'b0;
                    cnt_d      = c_cnt_load;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d      = {bin_q[p_data_width-2:0], 1'b0};
                scratch_d  = shifted;
                ovf_flag_d = ovf_flag_q | shift_out;
                cnt_d      = cnt_q - c_cnt_last;
                if (cnt_q == c_cnt_last) begin
                    // Last input bit: publish the result this cycle.
                    bcd_d   = shifted;
                    ovf_d   = ovf_flag_q | shift_out;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any conversion and does not
    // produce a done pulse.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            ovf_flag_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            ovf_flag_q <= ovf_flag_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SEQ_BIN2BCD_BLANK_EN
    logic [p_digits-1:0] blank_q, blank_d;
    logic [p_digits-1:0] blank_calc;
    logic                all_zero;

    // Leading-zero mask of the finished result. Bit i is set when digit i and
    // every digit above it are zero. Bit 0 stays clear so that 0 shows as "0".
    always_comb begin
        blank_calc = '0;
        all_zero   = 1'b1;
        for (int i = p_digits - 1; i >= 1; i--) begin
            all_zero      = all_zero & (shifted[4*i +: 4] == 4'd0);
            blank_calc[i] = all_zero;
        end
    end

    // Load the mask in the same cycle as the BCD result.
    always_comb begin
        blank_d = blank_q;
        if (done_d) begin
            blank_d = blank_calc;
        end
    end

    // Mask register, cleared by reset with the other outputs.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign o_w_blank = blank_q;
`else
    assign o_w_blank = '0;
`endif

    assign o_w_busy     = (state_q == ST_SHIFT);
    assign o_w_done     = done_q;
    assign o_w_bcd      = bcd_q;
    assign o_w_overflow = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Testbench for seq_bin2bcd: directed vectors with hand-computed expected
// values, for a 3-digit instance and a 2-digit instance (overflow cases).
module tb_seq_bin2bcd;

`ifdef SEQ_BIN2BCD_BLANK_EN
    localparam bit c_blank_en = 1'b1;
`else
    localparam bit c_blank_en = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 3-digit instance
    logic [7:0]  in1 = '0;
    logic        start1 = 1'b0;
    logic        busy1, done1, ovf1;
    logic [11:0] bcd1;
    logic [2:0]  blank1;

    // 2-digit instance
    logic [7:0]  in2 = '0;
    logic        start2 = 1'b0;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
    logic [1:0]  blank2;

    seq_bin2bcd #(.p_data_width(8), .p_digits(3)) dut (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in1), .i_w_start(start1),
        .o_w_busy(busy1), .o_w_done(done1), .o_w_bcd(bcd1),
        .o_w_overflow(ovf1), .o_w_blank(blank1)
    );

    seq_bin2bcd #(.p_data_width(8), .p_digits(2)) dut2 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_in(in2), .i_w_start(start2),
        .o_w_busy(busy2), .o_w_done(done2), .o_w_bcd(bcd2),
        .o_w_overflow(ovf2), .o_w_blank(blank2)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    int          got_at_q[$];
    logic        last_ovf;
    logic [2:0]  last_blank;

    function automatic logic [2:0] eb(input logic [2:0] b);
        return c_blank_en ? b : 3'b000;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic pulse_start(input bit sel2, input logic [7:0] v);
        if (sel2) begin in2 = v; start2 = 1'b1; end
        else      begin in1 = v; start1 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Samples n negedges (index 0 is the current one) and records every done
    // pulse in got_q/got_at_q. Optionally asserts start for one cycle at
    // index drive_at with value drive_val.
    task automatic watch(input int n, input bit sel2, input int drive_at,
                         input logic [7:0] drive_val,
                         output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (sel2 ? busy2 : busy1) busy_cnt++;
            if (sel2 ? done2 : done1) begin
                done_cnt++;
                got_q.push_back(sel2 ? {4'h0, bcd2} : bcd1);
                got_at_q.push_back(i);
                last_ovf   = sel2 ? ovf2 : ovf1;
                last_blank = sel2 ? {1'b0, blank2} : blank1;
            end
            start1 = 1'b0;
            start2 = 1'b0;
            if (i == drive_at) begin
                if (sel2) begin in2 = drive_val; start2 = 1'b1; end
                else      begin in1 = drive_val; start1 = 1'b1; end
            end
        end
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy1 !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        total++; if (done1 !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done1); end
        total++; if (bcd1 !== 12'h000)  begin bad++; $display("FAIL reset_bcd got=%h exp=000", bcd1); end
        total++; if (ovf1 !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf1); end
        total++; if (blank1 !== 3'b000) begin bad++; $display("FAIL reset_blank got=%b exp=000", blank1); end
        total++; if ({busy2, done2, bcd2, ovf2, blank2} !== 13'h0) begin
            bad++; $display("FAIL reset_dut2 got=%h exp=0", {busy2, done2, bcd2, ovf2, blank2});
        end
        rst = 1'b0;
    endtask

    task automatic test_convert_255;
        int bc, dc;
        got_q.delete(); got_at_q.delete();
        pulse_start(1'b0, 8'd255);
        watch(12, 1'b0, -1, 8'd0, bc, dc);
        total++; if (bc !== 8) begin bad++; $display("FAIL c255_busy_cycles got=%0d exp=8", bc); end
        total++; if (dc !== 1) begin bad++; $display("FAIL c255_done_count got=%0d exp=1", dc); end
        if (dc > 0) begin
            total++; if (got_at_q[0] !== 8) begin bad++; $display("FAIL c255_done_cycle got=%0d exp=8", got_at_q[0]); end
            total++; if (got_q[0] !== 12'h255) begin bad++; $display("FAIL c255_bcd got=%h exp=255", got_q[0]); end
            total++; if (last_ovf !== 1'b0) begin bad++; $display("FAIL c255_ovf got=%b exp=0", last_ovf); end
            total++; if (last_blank !== eb(3'b000)) begin bad++; $display("FAIL c255_blank got=%b exp=%b", last_blank, eb(3'b000)); end
        end
        total++; if (bcd1 !== 12'h255) begin bad++; $display("FAIL c255_held got=%h exp=255", bcd1); end
    endtask

    task automatic test_small_values;
        int bc, dc;
        got_q.delete(); got_at_q.delete();
        pulse_start(1'b0, 8'd7);
        watch(10, 1'b0, -1, 8'd0, bc, dc);
        total++; if (dc !== 1) begin bad++; $display("FAIL c7_done_count got=%0d exp=1", dc); end
        total++; if (bcd1 !== 12'h007) begin bad++; $display("FAIL c7_bcd got=%h exp=007", bcd1); end
        total++; if (blank1 !== eb(3'b110)) begin bad++; $display("FAIL c7_blank got=%b exp=%b", blank1, eb(3'b110)); end
        pulse_start(1'b0, 8'd0);
        watch(10, 1'b0, -1, 8'd0, bc, dc);
        total++; if (dc !== 1) begin bad++; $display("FAIL c0_done_count got=%0d exp=1", dc); end
        total++; if (bcd1 !== 12'h000) begin bad++; $display("FAIL c0_bcd got=%h exp=000", bcd1); end
        total++; if (blank1 !== eb(3'b110)) begin bad++; $display("FAIL c0_blank got=%b exp=%b", blank1, eb(3'b110)); end
    endtask

    task automatic test_start_while_busy;
        int bc, dc;
        got_q.delete(); got_at_q.delete();
        pulse_start(1'b0, 8'd100);
        // start with 42 asserted at index 1, sampled by the edge two after the first start
        watch(16, 1'b0, 1, 8'd42, bc, dc);
        total++; if (dc !== 1) begin bad++; $display("FAIL busy_start_done_count got=%0d exp=1", dc); end
        if (dc > 0) begin
            total++; if (got_at_q[0] !== 8) begin bad++; $display("FAIL busy_start_done_cycle got=%0d exp=8", got_at_q[0]); end
            total++; if (got_q[0] !== 12'h100) begin bad++; $display("FAIL busy_start_bcd got=%h exp=100", got_q[0]); end
        end
        total++; if (bc !== 8) begin bad++; $display("FAIL busy_start_busy_cycles got=%0d exp=8", bc); end
    endtask

    task automatic test_back_to_back;
        int bc, dc;
        logic [11:0] e, g;
        got_q.delete(); got_at_q.delete(); exp_q.delete();
        exp_q.push_back(12'h255);
        exp_q.push_back(12'h042);
        pulse_start(1'b0, 8'd255);
        // second start driven in the done cycle (index 8)
        watch(22, 1'b0, 8, 8'd42, bc, dc);
        total++; if (dc !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dc); end
        if (dc == 2) begin
            total++; if (got_at_q[1] - got_at_q[0] !== 9) begin
                bad++; $display("FAIL b2b_spacing got=%0d exp=9", got_at_q[1] - got_at_q[0]);
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL b2b_bcd got=%h exp=%h", g, e); end
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_abort;
        int bc, dc;
        got_q.delete(); got_at_q.delete();
        pulse_start(1'b0, 8'd99);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done1); end
        rst = 1'b0;
        watch(12, 1'b0, -1, 8'd0, bc, dc);
        total++; if (dc !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dc); end
        total++; if (bcd1 !== 12'h000) begin bad++; $display("FAIL abort_bcd got=%h exp=000", bcd1); end
        pulse_start(1'b0, 8'd99);
        watch(10, 1'b0, -1, 8'd0, bc, dc);
        total++; if (dc !== 1) begin bad++; $display("FAIL c99_done_count got=%0d exp=1", dc); end
        total++; if (bcd1 !== 12'h099) begin bad++; $display("FAIL c99_bcd got=%h exp=099", bcd1); end
        total++; if (blank1 !== eb(3'b100)) begin bad++; $display("FAIL c99_blank got=%b exp=%b", blank1, eb(3'b100)); end
    endtask

    task automatic test_overflow;
        int bc, dc;
        got_q.delete(); got_at_q.delete();
        pulse_start(1'b1, 8'd200);
        watch(10, 1'b1, -1, 8'd0, bc, dc);
        total++; if (dc !== 1) begin bad++; $display("FAIL ovf200_done_count got=%0d exp=1", dc); end
        total++; if (bcd2 !== 8'h00) begin bad++; $display("FAIL ovf200_bcd got=%h exp=00", bcd2); end
        total++; if (ovf2 !== 1'b1) begin bad++; $display("FAIL ovf200_flag got=%b exp=1", ovf2); end
        total++; if (blank2 !== eb(3'b010)) begin bad++; $display("FAIL ovf200_blank got=%b exp=%b", blank2, eb(3'b010)); end
        pulse_start(1'b1, 8'd99);
        watch(10, 1'b1, -1, 8'd0, bc, dc);
        total++; if (dc !== 1) begin bad++; $display("FAIL ovf99_done_count got=%0d exp=1", dc); end
        total++; if (bcd2 !== 8'h99) begin bad++; $display("FAIL ovf99_bcd got=%h exp=99", bcd2); end
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL ovf99_flag got=%b exp=0", ovf2); end
        total++; if (blank2 !== 2'b00) begin bad++; $display("FAIL ovf99_blank got=%b exp=00", blank2); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_convert_255();
        test_small_values();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
